// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised register file with a per-register busy scoreboard.
//
// Sits between decode (reads and destination claims) and writeback (writes)
// in the 16-bit core. Depth is 2**ADDR_W registers of DATA_W bits each.
//
// Optional feature macro: REGFILE_SB_BYPASS_EN
//   defined   : a same-cycle writeback to the read address is forwarded onto
//               rd_data_x, and rd_busy_x shows the post-writeback busy view.
//   undefined : reads return stored contents and the registered busy bit.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   rd_addr_a/b in   read port addresses
//   rd_data_a/b out  read data (combinational)
//   rd_busy_a/b out  busy bit of the read address (combinational)
//   wr_en       in   writeback strobe
//   wr_addr     in   writeback address
//   wr_data     in   writeback data
//   claim_en    in   decode requests ownership of claim_addr
//   claim_addr  in   register being claimed
//   claim_ok    out  claim accepted this cycle (combinational)
//   wr_err      out  registered one-cycle pulse: previous write hit a non-busy register
//   busy_vec    out  registered scoreboard, bit i = register i busy
//
// Handshake: claim_en is a request; claim_ok is its same-cycle grant. A
// request without a grant changes no state and decode simply retries.
// A pending writeback to the claimed register frees it in time for the claim.

module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int RST_R0   = 1,
    parameter int RST_R1   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    output logic                   rd_busy_a,
    output logic                   rd_busy_b,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   claim_en,
    input  logic [ADDR_W-1:0]      claim_addr,
    output logic                   claim_ok,
    output logic                   wr_err,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [DATA_W-1:0] R0_INIT = DATA_W'(RST_R0);
    localparam logic [DATA_W-1:0] R1_INIT = DATA_W'(RST_R1);
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr_err_q;

    // Address-0 hits that the hardwired-zero option turns into no-ops.
    logic zero_a, zero_b, zero_wr;
    logic wr_take;

    assign zero_a  = ZERO_EN && (rd_addr_a == '0);
    assign zero_b  = ZERO_EN && (rd_addr_b == '0);
    assign zero_wr = ZERO_EN && (wr_addr == '0);
    assign wr_take = wr_en && !zero_wr;

    // A writeback in the same cycle releases the register, so the claim may proceed.
    assign claim_ok = claim_en && (!busy[claim_addr] || (wr_en && (wr_addr == claim_addr)));

    // Scoreboard next state: writeback clears first, accepted claim sets second,
    // so a same-address write+claim leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (claim_ok) begin
            busy_next[claim_addr] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            wr_err_q <= 1'b0;
        end else begin
            busy     <= busy_next;
            wr_err_q <= wr_take && !busy[wr_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == 0) begin
                    regs[i] <= R0_INIT;
                end else if (i == 1) begin
                    regs[i] <= R1_INIT;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else if (wr_take) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic hit_a, hit_b;

    assign hit_a = wr_take && (wr_addr == rd_addr_a);
    assign hit_b = wr_take && (wr_addr == rd_addr_b);

    always_comb begin
        rd_data_a = zero_a ? '0 : regs[rd_addr_a];
        rd_data_b = zero_b ? '0 : regs[rd_addr_b];
        rd_busy_a = busy[rd_addr_a];
        rd_busy_b = busy[rd_addr_b];
        // The forwarded view shows the register as it will be after this edge:
        // free, unless a claim grabs it again in the same cycle.
        if (hit_a) begin
            rd_data_a = wr_data;
            rd_busy_a = claim_ok && (claim_addr == rd_addr_a);
        end
        if (hit_b) begin
            rd_data_b = wr_data;
            rd_busy_b = claim_ok && (claim_addr == rd_addr_b);
        end
    end
`else
    always_comb begin
        rd_data_a = zero_a ? '0 : regs[rd_addr_a];
        rd_data_b = zero_b ? '0 : regs[rd_addr_b];
        rd_busy_a = busy[rd_addr_a];
        rd_busy_b = busy[rd_addr_b];
    end
`endif

    assign wr_err   = wr_err_q;
    assign busy_vec = busy;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- Width and depth are configurable; two asynchronous read ports, one synchronous write port.
- Adds asynchronous reset, an optional hardwired-zero register and a per-register busy scoreboard for issue/writeback hazard tracking.
- Sits between decode (reads, claims) and writeback (writes) in the 16-bit core.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- RST_R0, 1, reset value of register 0 (truncated to DATA_W).
- RST_R1, 1, reset value of register 1; all other registers reset to 0.
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- rd_busy_a  out  1  busy bit of rd_addr_a (combinational)
- rd_busy_b  out  1  busy bit of rd_addr_b (combinational)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- claim_en  in  1  decode requests ownership of a destination register
- claim_addr  in  ADDR_W  register being claimed
- claim_ok  out  1  claim accepted this cycle (combinational)
- wr_err  out  1  registered one-cycle pulse: write to a non-busy register
- busy_vec  out  2**ADDR_W  registered scoreboard, bit i = register i busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - reg[0] = RST_R0, reg[1] = RST_R1, all others 0.
  - busy_vec = 0, wr_err = 0.
  - Reset takes effect immediately, even mid-claim or mid-write; no write lands that edge.
- Write:
  - On a posedge with wr_en=1, reg[wr_addr] <= wr_data.
  - New data is visible on the read ports the cycle after the edge (no bypass unless the optional feature is compiled in).
- Read: rd_data_x = reg[rd_addr_x]. If ZERO_REG=1 and rd_addr_x=0, rd_data_x = 0.
- ZERO_REG=1:
  - Writes to address 0 are discarded and never raise wr_err.
  - Claims to address 0 return claim_ok=1 but never set busy.
  - busy_vec[0] is held at 0.
- claim_ok = claim_en & (~busy[claim_addr] | (wr_en & wr_addr==claim_addr)).
- A rejected claim (claim_ok=0) changes no state; decode stalls and retries.
- Scoreboard update on each posedge, in this order:
  1. A write clears busy[wr_addr].
  2. An accepted claim then sets busy[claim_addr].
  - Same address in the same cycle: the claim wins and the bit ends at 1.
- wr_err:
  - Set the cycle after a write whose busy[wr_addr] was 0 before the edge; the write is still performed.
  - Cleared the following cycle unless the condition repeats.
- Independent read and claim addresses may alias freely; no other ordering constraints.
- Latency: reads and claim_ok have 0 cycles; state changes have 1 cycle.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - If wr_en=1 and wr_addr==rd_addr_x (and not the zero register when ZERO_REG=1), rd_data_x = wr_data combinationally in the same cycle.
  - rd_busy_x reads 0 under the same match condition, unless a claim to the same address is accepted in that cycle.
- Undefined: reads return stored contents only; rd_busy_x reflects the registered busy bit.

Test Plan:
- Reset then read all 8 addresses (defaults) -> 0x0001, 0x0001, then 0x0000 x6; busy_vec = 0; wr_err = 0.
- Claim r3 (claim_ok=1); next cycle claim r3 again -> claim_ok=0, busy_vec=0x08; write r3=0xBEEF -> busy_vec=0x00 next cycle, rd_data_a(r3)=0xBEEF, wr_err stays 0.
- r5 busy; same cycle wr r5=0x1234 and claim r5 -> claim_ok=1, busy_vec[5]=1 after the edge, r5=0x1234.
- Write r6=0x00AA while r6 not busy -> wr_err=1 for exactly one cycle, r6=0x00AA.
- ZERO_REG=1: write r0=0xFFFF, claim r0 -> rd_data(r0)=0, claim_ok=1, busy_vec[0]=0, wr_err=0.
- rst_n asserted mid-cycle with busy_vec=0xF0 and wr_en=1 to r2 -> busy_vec=0 immediately, r2 equals its reset value; with REGFILE_SB_BYPASS_EN defined, write r4=0x5555 while reading r4 -> rd_data=0x5555 in the same cycle.
